// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the reg_file_sb register file.
// Holds default geometry, byte-count helper and the zero-register index.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int ZERO_IDX  = 0;

    function automatic int nbytes(input int w);
        return w / 8;
    endfunction

endpackage

// File: rtl/reg_file_word.sv
// One WIDTH-bit register with synchronous reset and per-byte write enables.
// Ports: clk, rst (sync, active-high), i_be byte enables, i_d data, o_q value.
module reg_file_word
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [nbytes(WIDTH)-1:0]  i_be,
    input  logic [WIDTH-1:0]          i_d,
    output logic [WIDTH-1:0]          o_q
);

    localparam int NB = nbytes(WIDTH);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (i_be[k]) r_q[8*k +: 8] <= i_d[8*k +: 8];
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file (2R/1W, byte strobes) with a per-register busy scoreboard.
// Ports: clk, rst, write port (we/waddr/wdata/wstrb), read ports
// (raddrN -> rdataN, busyN), busy set (set_busy/set_addr), busy_cnt.
// Macro REGFILE_BYPASS_EN: forward same-cycle write data onto read ports.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [nbytes(WIDTH)-1:0] wstrb,
    input  logic [AW-1:0]            raddr1,
    input  logic [AW-1:0]            raddr2,
    output logic [WIDTH-1:0]         rdata1,
    output logic [WIDTH-1:0]         rdata2,
    input  logic                     set_busy,
    input  logic [AW-1:0]            set_addr,
    output logic                     busy1,
    output logic                     busy2,
    output logic [AW:0]              busy_cnt
);

    localparam int NB = nbytes(WIDTH);
    localparam logic [AW-1:0] ZADDR = AW'(ZERO_IDX);

    logic [WIDTH-1:0] w_q  [DEPTH];
    logic [NB-1:0]    w_be [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      r_cnt;
    logic [AW:0]      w_cnt_nxt;
    logic             w_wr_ok;
    logic             w_set_ok;
    logic [AW-1:0]    w_ra   [2];
    logic [WIDTH-1:0] w_rd   [2];
    logic             w_rb   [2];

    // Writes and busy-sets aimed at a hardwired-zero register are dropped.
    assign w_wr_ok  = we && !((ZERO_REG != 0) && (waddr == ZADDR));
    assign w_set_ok = set_busy && !((ZERO_REG != 0) && (set_addr == ZADDR));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            assign w_be[gi] = (w_wr_ok && (waddr == AW'(gi))) ? wstrb : '0;
            reg_file_word #(.WIDTH(WIDTH)) u_word (
                .clk  (clk),
                .rst  (rst),
                .i_be (w_be[gi]),
                .i_d  (wdata),
                .o_q  (w_q[gi])
            );
        end
    endgenerate

    // Clear before set so a same-address set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok)  w_busy_nxt[waddr]    = 1'b0;
        if (w_set_ok) w_busy_nxt[set_addr] = 1'b1;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [WIDTH-1:0] w_merged;

    always_comb begin
        w_merged = w_q[waddr];
        for (int k = 0; k < NB; k++) begin
            if (wstrb[k]) w_merged[8*k +: 8] = wdata[8*k +: 8];
        end
    end
`endif

    assign w_ra[0] = raddr1;
    assign w_ra[1] = raddr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            always_comb begin
                w_rd[gi] = w_q[w_ra[gi]];
                w_rb[gi] = r_busy[w_ra[gi]];
`ifdef REGFILE_BYPASS_EN
                if (w_wr_ok && (w_ra[gi] == waddr)) begin
                    w_rd[gi] = w_merged;
                    w_rb[gi] = w_set_ok && (set_addr == waddr);
                end
`endif
                if ((ZERO_REG != 0) && (w_ra[gi] == ZADDR)) begin
                    w_rd[gi] = '0;
                    w_rb[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign rdata1   = w_rd[0];
    assign rdata2   = w_rd[1];
    assign busy1    = w_rb[0];
    assign busy2    = w_rb[1];
    assign busy_cnt = r_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized + directed self-checking bench for reg_file_sb.
// Behavioural model: plain arrays updated from the write/busy rules.
module tb_reg_file_sb;

    localparam int W = 32;
    localparam int D = 32;
    localparam int A = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [A-1:0] waddr;
    logic [W-1:0] wdata;
    logic [3:0]   wstrb;
    logic [A-1:0] raddr1;
    logic [A-1:0] raddr2;
    logic [W-1:0] rdata1;
    logic [W-1:0] rdata2;
    logic         set_busy;
    logic [A-1:0] set_addr;
    logic         busy1;
    logic         busy2;
    logic [A:0]   busy_cnt;

    reg_file_sb #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .set_busy (set_busy),
        .set_addr (set_addr),
        .busy1    (busy1),
        .busy2    (busy2),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    logic [W-1:0] m_reg [D];
    bit           m_busy [D];
    int           m_cnt;
    int           checks = 0;
    int           failures = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic logic [W-1:0] exp_data(input logic [A-1:0] a);
        logic [W-1:0] v;
        if (a == 0) return '0;
        v = m_reg[a];
        if (BYP && !rst && we && waddr == a) begin
            for (int k = 0; k < 4; k++)
                if (wstrb[k]) v[8*k +: 8] = wdata[8*k +: 8];
        end
        return v;
    endfunction

    function automatic logic exp_busy(input logic [A-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP && !rst && we && waddr == a)
            return set_busy && set_addr == a;
        return m_busy[a];
    endfunction

    task automatic cmp_all();
        check("rdata1", rdata1, exp_data(raddr1));
        check("rdata2", rdata2, exp_data(raddr2));
        check("busy1", W'(busy1), W'(exp_busy(raddr1)));
        check("busy2", W'(busy2), W'(exp_busy(raddr2)));
        check("busy_cnt", W'(busy_cnt), W'(m_cnt));
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                m_reg[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_cnt = 0;
            return;
        end
        if (we && waddr != 0) begin
            for (int k = 0; k < 4; k++)
                if (wstrb[k]) m_reg[waddr][8*k +: 8] = wdata[8*k +: 8];
            if (m_busy[waddr]) begin
                m_busy[waddr] = 1'b0;
                m_cnt--;
            end
        end
        if (set_busy && set_addr != 0 && !m_busy[set_addr]) begin
            m_busy[set_addr] = 1'b1;
            m_cnt++;
        end
    endtask

    task automatic tick();
        #1;
        cmp_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic iwe, input logic [A-1:0] iwa,
                         input logic [W-1:0] iwd, input logic [3:0] iws,
                         input logic [A-1:0] ir1, input logic [A-1:0] ir2,
                         input logic isb, input logic [A-1:0] isa);
        we = iwe; waddr = iwa; wdata = iwd; wstrb = iws;
        raddr1 = ir1; raddr2 = ir2; set_busy = isb; set_addr = isa;
    endtask

    task automatic idle(input logic [A-1:0] ir1, input logic [A-1:0] ir2);
        drive(1'b0, '0, '0, '0, ir1, ir2, 1'b0, '0);
    endtask

    task automatic rand_cycles(input int n, input bit allow_rst);
        for (int i = 0; i < n; i++) begin
            rst = allow_rst && ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 2) != 0, A'($urandom), $urandom,
                  4'($urandom), A'($urandom), A'($urandom),
                  $urandom_range(0, 2) != 0, A'($urandom));
            if ($urandom_range(0, 3) == 0) raddr1 = waddr;
            if ($urandom_range(0, 3) == 0) set_addr = waddr;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle('0, '0);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        rand_cycles(300, 1'b1);

        // Reset after random traffic, with a write and set pending.
        rst = 1'b1;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd9, 1'b1, 5'd9);
        tick();
        rst = 1'b0;
        idle(5'd5, 5'd9);
        #1;
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_rdata2", rdata2, 32'h0);
        check("rst_cnt", W'(busy_cnt), 32'd0);
        check("rst_busy2", W'(busy2), 32'd0);

        // Byte strobes.
        drive(1'b1, 5'd5, 32'hAABBCCDD, 4'hF, 5'd1, 5'd2, 1'b0, '0);
        tick();
        drive(1'b1, 5'd5, 32'h11223344, 4'b0101, 5'd1, 5'd2, 1'b0, '0);
        tick();
        idle(5'd5, 5'd5);
        #1;
        check("strb_data", rdata1, 32'hAA22CC44);
        tick();

        // Zero register.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 1'b1, 5'd0);
        tick();
        idle(5'd0, 5'd0);
        #1;
        check("zero_data", rdata1, 32'h0);
        check("zero_busy", W'(busy1), 32'd0);
        check("zero_cnt", W'(busy_cnt), 32'd0);
        tick();

        // Scoreboard set/clear.
        drive(1'b0, '0, '0, '0, 5'd3, 5'd7, 1'b1, 5'd3);
        tick();
        drive(1'b0, '0, '0, '0, 5'd3, 5'd7, 1'b1, 5'd7);
        tick();
        idle(5'd3, 5'd7);
        #1;
        check("sb_cnt2", W'(busy_cnt), 32'd2);
        check("sb_busy3", W'(busy1), 32'd1);
        drive(1'b1, 5'd3, 32'h5, 4'hF, 5'd8, 5'd7, 1'b0, '0);
        tick();
        idle(5'd3, 5'd7);
        #1;
        check("sb_cnt1", W'(busy_cnt), 32'd1);
        check("sb_busy3_clr", W'(busy1), 32'd0);
        check("sb_busy7", W'(busy2), 32'd1);
        tick();

        // Same-cycle set and write on busy reg 9.
        drive(1'b0, '0, '0, '0, 5'd9, 5'd7, 1'b1, 5'd9);
        tick();
        drive(1'b1, 5'd9, 32'h12345678, 4'hF, 5'd8, 5'd7, 1'b1, 5'd9);
        tick();
        idle(5'd9, 5'd7);
        #1;
        check("sc_busy9", W'(busy1), 32'd1);
        check("sc_cnt", W'(busy_cnt), 32'd2);
        check("sc_data", rdata1, 32'h12345678);
        tick();

        // Read during write.
        drive(1'b1, 5'd12, 32'h1, 4'hF, 5'd1, 5'd2, 1'b0, '0);
        tick();
        drive(1'b1, 5'd12, 32'h2, 4'hF, 5'd12, 5'd2, 1'b0, '0);
        #1;
        check("rdw_data", rdata1, BYP ? 32'h2 : 32'h1);
        tick();
        idle(5'd12, 5'd2);
        #1;
        check("rdw_after", rdata1, 32'h2);
        tick();

        rand_cycles(400, 1'b0);
        rand_cycles(200, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
